bit_serializer: RTL and testbench

Upstream feeder for the serial pattern detector. Accepts parallel bytes over a valid/ready handshake, buffers them in a small FIFO and shifts them out one bit per clock on `ser_bit`/`ser_valid`. Consecutive buffered bytes are emitted with no gap, so the downstream detector sees a contiguous bit stream.

---
 rtl/bit_serializer_pkg.sv | 16 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/bit_serializer.sv | 91 +++++++++
 tb/tb_bit_serializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the bit serializer and its FIFO.
package bit_serializer_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(FIFO_DEPTH_DEF);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push is ignored while full and pop while empty.
module sync_fifo
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Full/empty come from the registered count, so a pop never frees room for a same-cycle push.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Buffers parallel words and shifts them out one bit per clock, back to back.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           ser_bit,
  output logic                           ser_valid,
  output logic                           busy,
  output logic [cnt_w(FIFO_DEPTH)-1:0]   fifo_count
);
  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state, state_nxt;
  logic              pop, full, empty;
  logic [DATA_W-1:0] shreg, rdata;
  logic [BCW-1:0]    bit_cnt;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (rdata),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = ~full;
  assign busy     = (state == SHIFT) | ~empty;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Reload on the last-bit cycle keeps the stream gap-free between words.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ser_valid <= 1'b0;
      ser_bit   <= IDLE_BIT;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      if (state == SHIFT) begin
        ser_valid <= 1'b1;
        ser_bit   <= MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
        shreg     <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        bit_cnt   <= bit_cnt - 1'b1;
      end else begin
        ser_valid <= 1'b0;
        ser_bit   <= IDLE_BIT;
      end
      if (pop) begin
        shreg   <= rdata;
        bit_cnt <= BCW'(DATA_W - 1);
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: queue-based reference model per configuration plus directed literal checks.
module tb_bit_serializer;
  localparam int CW    = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  bit         chk_en = 1'b1;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // cfg0: MSB first, idle 0.  cfg1: LSB first, idle 1.
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam bit MSB  = (g == 0);
    localparam bit IDLV = (g == 1);

    logic          in_ready, ser_bit, ser_valid, busy;
    logic [CW-1:0] fifo_count;

    bit_serializer #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(MSB), .IDLE_BIT(IDLV)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ser_bit    (ser_bit),
      .ser_valid  (ser_valid),
      .busy       (busy),
      .fifo_count (fifo_count)
    );

    logic [7:0] fq[$];
    bit         sb[$];
    bit         m_valid, m_bit, m_acc;

    // Model: word queue plus queue of bits still owed by the current word.
    always @(posedge clk) begin
      int pre;
      logic [7:0] w;
      m_acc = 1'b0;
      if (reset) begin
        fq.delete();
        sb.delete();
        m_valid = 1'b0;
        m_bit   = IDLV;
      end else begin
        pre   = fq.size();
        m_acc = in_valid && (pre != DEPTH);
        if (sb.size() > 0) begin
          m_valid = 1'b1;
          m_bit   = sb.pop_front();
        end else begin
          m_valid = 1'b0;
          m_bit   = IDLV;
        end
        if (sb.size() == 0 && pre > 0) begin
          w = fq.pop_front();
          for (int i = 0; i < 8; i++) sb.push_back(MSB ? w[7-i] : w[i]);
        end
        if (m_acc) fq.push_back(in_data);
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("cfg%0d.ser_valid", g), 64'(ser_valid), 64'(m_valid));
        chk($sformatf("cfg%0d.ser_bit", g), 64'(ser_bit), 64'(m_bit));
        chk($sformatf("cfg%0d.busy", g), 64'(busy), 64'((sb.size() > 0) || (fq.size() > 0)));
        chk($sformatf("cfg%0d.fifo_count", g), 64'(fifo_count), 64'(fq.size()));
        chk($sformatf("cfg%0d.in_ready", g), 64'(in_ready), 64'(fq.size() != DEPTH));
      end
    end
  end

  // Gathers n valid bits from cfg0 starting at the current cycle, counting gaps after the first.
  task automatic collect(input int n, output logic [63:0] bits, output int gaps, output int got);
    bits = '0;
    gaps = 0;
    got  = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      if (cfg[0].ser_valid) begin
        bits = {bits[62:0], cfg[0].ser_bit};
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      if (got < n) cyc();
    end
  endtask

  initial begin
    logic [63:0] bits;
    logic [7:0]  v;
    logic [7:0]  wl [0:6];
    int gaps, got, vc, idx, guard;
    bit saw_full;

    wl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) cyc();
    chk("rst_ser_valid", 64'(cfg[0].ser_valid), 64'd0);
    chk("rst_ser_bit",   64'(cfg[0].ser_bit),   64'd0);
    chk("rst_busy",      64'(cfg[0].busy),      64'd0);
    chk("rst_fifo_count",64'(cfg[0].fifo_count),64'd0);
    chk("rst_in_ready",  64'(cfg[0].in_ready),  64'd1);
    chk("rst_idle1_bit", 64'(cfg[1].ser_bit),   64'd1);
    reset = 1'b0;
    repeat (2) cyc();

    // Single word 0xB0: accepted at edge N, bits after N+2..N+9
    in_valid = 1'b1; in_data = 8'hB0;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("b0_no_bit_at_n1", 64'(cfg[0].ser_valid), 64'd0);
    v = '0; vc = 0;
    repeat (8) begin
      cyc();
      vc += int'(cfg[0].ser_valid);
      v = {v[6:0], cfg[0].ser_bit};
    end
    chk("b0_bits", 64'(v), 64'hB0);
    chk("b0_valid_cycles", 64'(vc), 64'd8);
    cyc();
    chk("b0_after_valid", 64'(cfg[0].ser_valid), 64'd0);
    chk("b0_after_bit",   64'(cfg[0].ser_bit),   64'd0);
    repeat (3) cyc();

    // Back-to-back three words
    in_valid = 1'b1;
    in_data = 8'h0B; cyc();
    in_data = 8'hB0; cyc();
    in_data = 8'hFF; cyc();
    in_valid = 1'b0;
    collect(24, bits, gaps, got);
    chk("b2b_got",  64'(got), 64'd24);
    chk("b2b_bits", {40'd0, bits[23:0]}, 64'h0BB0FF);
    chk("b2b_gaps", 64'(gaps), 64'd0);
    repeat (4) cyc();

    // Full FIFO: 7 words with in_valid held
    idx = 0; saw_full = 1'b0; guard = 0;
    fork
      begin
        in_valid = 1'b1;
        while (idx < 7 && guard < 300) begin
          in_data = wl[idx];
          cyc();
          guard++;
          if (cfg[0].m_acc) idx++;
          if (cfg[0].fifo_count == 3'd4 && !cfg[0].in_ready) saw_full = 1'b1;
        end
        in_valid = 1'b0;
      end
      collect(56, bits, gaps, got);
    join
    chk("full_accepted", 64'(idx), 64'd7);
    chk("full_saw_full", 64'(saw_full), 64'd1);
    chk("full_got",  64'(got), 64'd56);
    chk("full_bits", {8'd0, bits[55:0]}, 64'h11223344556677);
    chk("full_gaps", 64'(gaps), 64'd0);
    repeat (4) cyc();

    // Reset after 3 bits of 0xB0 with two words queued
    in_valid = 1'b1;
    in_data = 8'hB0; cyc();
    in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    in_valid = 1'b0;
    vc = 0;
    for (int c = 0; c < 30; c++) begin
      if (cfg[0].ser_valid) vc++;
      if (vc == 3) break;
      cyc();
    end
    chk("mid_bits_seen", 64'(vc), 64'd3);
    chk("mid_queued", 64'(cfg[0].fifo_count), 64'd2);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("mid_rst_valid", 64'(cfg[0].ser_valid),  64'd0);
    chk("mid_rst_count", 64'(cfg[0].fifo_count), 64'd0);
    chk("mid_rst_busy",  64'(cfg[0].busy),       64'd0);
    vc = 0;
    repeat (20) begin cyc(); vc += int'(cfg[0].ser_valid); end
    chk("mid_no_leftover", 64'(vc), 64'd0);

    // LSB first, idle 1, word 0x0D
    in_valid = 1'b1; in_data = 8'h0D; cyc(); in_valid = 1'b0;
    v = '0; got = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      cyc();
      if (cfg[1].ser_valid) begin v = {v[6:0], cfg[1].ser_bit}; got++; end
    end
    chk("lsb_got",  64'(got), 64'd8);
    chk("lsb_bits", 64'(v), 64'b10110000);
    cyc();
    chk("lsb_idle_valid", 64'(cfg[1].ser_valid), 64'd0);
    chk("lsb_idle_bit",   64'(cfg[1].ser_bit),   64'd1);

    // Random traffic with alternating load and rare resets
    for (int i = 0; i < 3000; i++) begin
      if (((i / 500) % 2) == 0) in_valid = ($urandom_range(0, 3) != 0);
      else                      in_valid = ($urandom_range(0, 9) == 0);
      in_data = 8'($urandom);
      reset   = ($urandom_range(0, 199) == 0);
      cyc();
    end
    in_valid = 1'b0; reset = 1'b0;
    repeat (60) cyc();
    chk("drain_busy",  64'(cfg[0].busy),  64'd0);
    chk("drain_busy1", 64'(cfg[1].busy),  64'd0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
